// File: rtl/mem_unit.sv
// Word-addressed single-port synchronous memory mapped at a fixed byte base address.
// One read or write per rising clock edge; read data is registered with one cycle of latency.
module mem_unit #(
   parameter int                       data_width    = 32,
   parameter int                       address_width = 32,
   parameter int                       mem_depth     = 262144,
   parameter logic [address_width-1:0] base_address  = 32'h80020000
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [address_width-1:0] address,
   input  logic [data_width-1:0]    data_in,
   input  logic                     read_write,
   input  logic                     enable,
   output logic [data_width-1:0]    data_out
);

   localparam int                       IDX_W   = $clog2(mem_depth);
   localparam logic [address_width-1:0] DEPTH_A = address_width'(mem_depth);

   // Left without reset so that images loaded hierarchically survive a reset.
   logic [data_width-1:0] mem [mem_depth];

   logic [address_width-1:0] offset;
   logic [address_width-1:0] word_idx;
   logic [IDX_W-1:0]         idx;
   logic                     in_range;
   logic                     rd_en;
   logic                     wr_en;
   logic [data_width-1:0]    data_out_q;

   // The subtraction wraps modulo 2^address_width, so the lower-bound test is kept explicitly.
   assign offset   = address - base_address;
   assign word_idx = offset >> 2;
   assign idx      = word_idx[IDX_W-1:0];
   assign in_range = (address >= base_address) && (word_idx < DEPTH_A);

   assign rd_en = enable && read_write;
   assign wr_en = enable && !read_write && in_range && !reset;

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[idx] <= data_in;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         data_out_q <= '0;
      end else if (rd_en) begin
         data_out_q <= in_range ? mem[idx] : '0;
      end
   end

   assign data_out = data_out_q;

endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit: a reference array tracks the expected contents and every
// cycle's expected data_out is queued at drive time and compared one edge later.
module tb_mem_unit;

   localparam int          DEPTH = 262144;
   localparam logic [31:0] BASE  = 32'h80020000;

   logic        clock;
   logic        reset;
   logic [31:0] address;
   logic [31:0] data_in;
   logic        read_write;
   logic        enable;
   logic [31:0] data_out;

   logic [31:0] model [DEPTH];
   logic [31:0] exp_dout;
   logic [31:0] exp_q[$];
   string       tag_q[$];
   int          n_checks;
   int          n_fail;

   mem_unit dut (
      .clock      (clock),
      .reset      (reset),
      .address    (address),
      .data_in    (data_in),
      .read_write (read_write),
      .enable     (enable),
      .data_out   (data_out)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference helpers ----------------
   function automatic logic model_in_range(input logic [31:0] a);
      logic [31:0] wi;
      wi = (a - BASE) >> 2;
      return (a >= BASE) && (wi < 32'(DEPTH));
   endfunction

   function automatic int model_idx(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   function automatic logic [31:0] img(input logic [31:0] seed, input int k);
      return (32'(k) * 32'h9E3779B1) ^ seed;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step(input logic rst, input logic en, input logic rw,
                       input logic [31:0] a, input logic [31:0] d, input string tag);
      @(negedge clock);
      reset      = rst;
      enable     = en;
      read_write = rw;
      address    = a;
      data_in    = d;
      if (rst) begin
         exp_dout = '0;
      end else if (en && rw) begin
         exp_dout = model_in_range(a) ? model[model_idx(a)] : 32'h0;
      end else if (en && !rw && model_in_range(a)) begin
         model[model_idx(a)] = d;
      end
      exp_q.push_back(exp_dout);
      tag_q.push_back(tag);
   endtask

   task automatic rd(input logic [31:0] a, input string tag);
      step(1'b0, 1'b1, 1'b1, a, $urandom, tag);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
      step(1'b0, 1'b1, 1'b0, a, d, tag);
   endtask

   // Loads an image directly into the array during an idle cycle, like a hex-file load.
   task automatic preload(input logic [31:0] seed, input int count);
      step(1'b0, 1'b0, 1'b1, BASE, 32'h0, "preload_idle");
      for (int k = 0; k < count; k++) begin
         dut.mem[k] = img(seed, k);
         model[k]   = img(seed, k);
      end
   endtask

   task automatic check_array(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (dut.mem[i] !== model[i]) bad++;
      end
      check(tag, 32'(bad), 32'h0);
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic [31:0] e;
      string       t;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, data_out, e);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] a;
      int          waited;
      n_checks   = 0;
      n_fail     = 0;
      exp_dout   = '0;
      reset      = 1'b1;
      enable     = 1'b0;
      read_write = 1'b1;
      address    = BASE;
      data_in    = '0;

      step(1'b1, 1'b0, 1'b1, BASE, 32'h0, "reset0");
      step(1'b1, 1'b1, 1'b1, BASE, 32'h0, "reset1");

      // Full-array image, then streamed back-to-back reads of the first 56 words.
      preload(32'hA5A5_0F0F, DEPTH);
      for (int i = 0; i < 56; i++) rd(BASE + 32'(4 * i), "stream_rd");
      step(1'b0, 1'b0, 1'b1, BASE, 32'h0, "idle_after_stream");

      // Write then read back, including an unaligned address to the same word.
      wr(32'h80020010, 32'hDEADBEEF, "wr_hold");
      rd(32'h80020010, "rd_after_wr");
      rd(32'h80020013, "rd_unaligned");

      // Out-of-range boundaries: reads return 0, writes are dropped.
      rd(32'h80020000, "rd_base");
      rd(32'h8001FFFC, "rd_below_base");
      rd(32'h8011FFFC, "rd_last_word");
      rd(32'h80120000, "rd_past_end");
      rd(32'h00000000, "rd_zero_addr");
      wr(32'h8001FFFC, 32'h11111111, "wr_below_base");
      wr(32'h80120000, 32'h22222222, "wr_past_end");
      rd(32'h8011FFFC, "rd_last_after_oob_wr");
      check_array("array_after_oob_wr");

      // Random mix of in-range and out-of-range accesses near both ends.
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 3))
            0: a = BASE + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
            1: a = BASE - 32'($urandom_range(1, 64));
            2: a = 32'h80120000 - 32'h100 + 32'($urandom_range(0, 511));
            default: a = BASE + 32'($urandom_range(0, 63) * 4);
         endcase
         if ($urandom_range(0, 1) == 0) rd(a, "rand_rd");
         else wr(a, $urandom, "rand_wr");
      end

      // Idle cycles hold data_out and leave the array alone.
      rd(32'h80020004, "rd_before_idle");
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, $urandom_range(0, 1) == 1, BASE + 32'($urandom_range(0, 255) * 4),
              $urandom, "idle_hold");
      end
      check_array("array_after_idle");

      // Reset clears data_out, keeps the array, and blocks a concurrent write.
      rd(32'h80020020, "rd_before_reset");
      step(1'b1, 1'b1, 1'b0, 32'h80020020, 32'h12345678, "reset_with_wr");
      step(1'b0, 1'b0, 1'b1, 32'h80020020, 32'h0, "idle_after_reset");
      rd(32'h80020020, "rd_after_reset");
      check_array("array_after_reset");

      // Second image loaded mid-run is visible without reset.
      preload(32'h0BAD_F00D, 64);
      for (int i = 0; i < 64; i++) rd(BASE + 32'(4 * i), "reload_rd");
      step(1'b0, 1'b0, 1'b1, BASE, 32'h0, "final_idle");

      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(posedge clock);
         #2;
         waited++;
      end
      check("drain", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
